// File: rtl/jt900h_fetch.sv
// jt900h_fetch: byte-wide instruction prefetch queue feeding the microcode
// controller. Fetches 16-bit little-endian words, presents the head byte and
// the byte after it, tracks the PC of the head byte and redirects on jumps.
// Optional build macro: JT900H_FETCH_STALL_EN adds a saturating stall counter
// output (stall_cnt) that counts pops refused for lack of queued bytes.
module jt900h_fetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  input  logic [1:0]    pop,
  output logic [7:0]    md,
  output logic [7:0]    md2,
  output logic          md_valid,
  output logic          md2_valid,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] bus_addr,
  output logic          bus_rd,
  input  logic          bus_ack,
  input  logic [15:0]   bus_din
`ifdef JT900H_FETCH_STALL_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Byte storage; only the slots between head and head+count are meaningful
  logic [7:0]    mem_q [DEPTH];

  logic [PW-1:0] head_q,     head_d;
  logic [CW-1:0] count_q,    count_d;
  logic [AW-1:0] pc_q,       pc_d;
  logic [AW-1:0] fa_q,       fa_d;
  logic          bus_rd_q,   bus_rd_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic          run_q,      run_d;
  logic          discard_q,  discard_d;
`ifdef JT900H_FETCH_STALL_EN
  logic [15:0]   stall_q,    stall_d;
`endif

  logic [CW-1:0] free;
  logic          ack_fire;
  logic          keep;
  logic [CW-1:0] enq_n;
  logic          pop_avail;
  logic          pop_ok;
  logic [CW-1:0] pop_n;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr1;
  logic [PW-1:0] head1;
  logic          req;

  // Next-state computation for queue bookkeeping, PC, fetch pointer and bus handshake
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    ack_fire  = bus_rd_q & bus_ack;
    // Data returning for a flushed request, or arriving with a redirect, is dropped
    keep      = ack_fire & ~discard_q & ~pc_load;
    enq_n     = keep ? (fa_q[0] ? CW'(1) : CW'(2)) : CW'(0);
    pop_avail = ((pop == 2'd1) && (count_q >= CW'(1))) ||
                ((pop == 2'd2) && (count_q >= CW'(2)));
    pop_ok    = pop_avail & ~pc_load;
    pop_n     = pop_ok ? CW'(pop) : CW'(0);
    // Tail slot is unaffected by a simultaneous pop, so it is based on the old head
    wr_ptr    = head_q + PW'(count_q);
    wr_ptr1   = wr_ptr + PW'(1);
    head1     = head_q + PW'(1);
    // Space is judged on the pre-pop count, so an in-flight word always fits
    req       = ~bus_rd_q & run_q & ~discard_q & ~pc_load &
                ((free >= CW'(2)) || (fa_q[0] && (free >= CW'(1))));

    head_d     = head_q + PW'(pop_n);
    count_d    = pc_load ? CW'(0) : (count_q - pop_n + enq_n);
    pc_d       = pc_load ? pc_in : (pc_q + AW'(pop_n));
    fa_d       = fa_q;
    if (pc_load)
      fa_d = pc_in;
    else if (keep)
      fa_d = fa_q + (fa_q[0] ? AW'(1) : AW'(2));
    run_d      = run_q | pc_load;

    bus_rd_d   = bus_rd_q;
    bus_addr_d = bus_addr_q;
    if (ack_fire)
      bus_rd_d = 1'b0;
    else if (req) begin
      bus_rd_d   = 1'b1;
      bus_addr_d = {fa_q[AW-1:1], 1'b0};
    end

    // A redirect never aborts a bus cycle; the late data is tagged for discard
    discard_d = discard_q;
    if (ack_fire)
      discard_d = 1'b0;
    else if (pc_load && bus_rd_q)
      discard_d = 1'b1;

`ifdef JT900H_FETCH_STALL_EN
    stall_d = stall_q;
    if (!pc_load && ((pop == 2'd1) || (pop == 2'd2)) && !pop_avail && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
`endif
  end

  // Control state registers; reset is not qualified by cen
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q     <= '0;
      count_q    <= '0;
      pc_q       <= '0;
      fa_q       <= '0;
      bus_rd_q   <= 1'b0;
      bus_addr_q <= '0;
      run_q      <= 1'b0;
      discard_q  <= 1'b0;
`ifdef JT900H_FETCH_STALL_EN
      stall_q    <= '0;
`endif
    end else if (cen) begin
      head_q     <= head_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      fa_q       <= fa_d;
      bus_rd_q   <= bus_rd_d;
      bus_addr_q <= bus_addr_d;
      run_q      <= run_d;
      discard_q  <= discard_d;
`ifdef JT900H_FETCH_STALL_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // Byte storage writes: odd fetch address keeps only the upper byte of the word
  always_ff @(posedge clk) begin
    if (rst && cen && keep) begin
      if (fa_q[0]) begin
        mem_q[wr_ptr] <= bus_din[15:8];
      end else begin
        mem_q[wr_ptr]  <= bus_din[7:0];
        mem_q[wr_ptr1] <= bus_din[15:8];
      end
    end
  end

  // Output mapping; bytes read as zero when not valid
  always_comb begin
    md_valid  = (count_q >= CW'(1));
    md2_valid = (count_q >= CW'(2));
    md        = md_valid  ? mem_q[head_q] : 8'h00;
    md2       = md2_valid ? mem_q[head1]  : 8'h00;
    pc        = pc_q;
    bus_addr  = bus_addr_q;
    bus_rd    = bus_rd_q;
`ifdef JT900H_FETCH_STALL_EN
    stall_cnt = stall_q;
`endif
  end

endmodule

// File: doc/jt900h_fetch.md
Name: jt900h_fetch

Overview:
Instruction prefetch queue that sits directly upstream of the microcode controller. It fetches 16-bit words from the bus and presents the head opcode/operand byte on md[7:0] to the controller, together with the following byte. It tracks the program counter of the head byte and redirects fetching on jumps. Because it owns the 24-bit fetch address, the controller can consume 1 or 2 bytes per cycle.

Parameters:
DEPTH, 4, queue size in bytes; must be a power of two and at least 4.
AW, 24, address width.

Ports:
clk      in   1   clock
rst      in   1   synchronous reset, active-low
cen      in   1   clock enable; all state updates only when cen=1
pc_load  in   1   flush queue and redirect fetch to pc_in
pc_in    in   AW  new program counter
pop      in   2   bytes consumed this cycle (0, 1 or 2; 3 is treated as 0)
md       out  8   head byte
md2      out  8   byte after head
md_valid out  1   at least 1 byte queued
md2_valid out 1   at least 2 bytes queued
pc       out  AW  address of head byte
bus_addr out  AW  word-aligned fetch address (bit0 always 0)
bus_rd   out  1   read request
bus_ack  in   1   read data valid on bus_din; sampled only when cen=1
bus_din  in   16  read data, little endian: [7:0]=even byte, [15:8]=odd byte

Behaviour:
Reset (rst=0 at a clk edge), with no cen qualification:
- count=0, md_valid=md2_valid=0, md=md2=0.
- pc=0, fetch pointer fa=0, bus_rd=0, bus_addr=0.
- A "run" flag is cleared. No fetch occurs until the first pc_load.

Free space is free = DEPTH - count.

Request:
- When bus_rd=0, run=1, there is no pending flush discard, and free>=2 (or free>=1 when fa[0]=1), assert bus_rd=1 on the next cen edge.
- bus_addr = {fa[AW-1:1],1'b0}.
- bus_rd and bus_addr stay stable until bus_ack; only one request is outstanding.

Acknowledge (bus_rd=1, bus_ack=1, cen=1):
- If fa[0]=0, enqueue bus_din[7:0] then bus_din[15:8], and fa += 2.
- If fa[0]=1, enqueue only bus_din[15:8], and fa += 1.
- bus_rd drops in the same edge. The next request can be raised on the following cen edge at the earliest.
- Enqueued bytes are visible on md/md2 the cycle after the ack.

Pop:
- pop=1 needs md_valid; pop=2 needs md2_valid. Otherwise the pop is ignored entirely, with no partial pop.
- A successful pop advances the head by pop and sets pc += pop.

Simultaneous pop and ack:
- Both apply, and count_next = count - pop + enq.
- A pop can free the space the ack fills.
- Free space is checked against count before the pop, so the queue never overflows.

Flush (pc_load=1, cen=1):
- count=0, pc=pc_in, fa=pc_in, run=1.
- pop is ignored on the same cycle.
- If a request is outstanding, it is not aborted: bus_rd is held until bus_ack and that data is discarded via a discard flag.
- A new request is raised after the discarded ack.
- pc_load on the same edge as an ack: the data is discarded, and fetching restarts at pc_in next cycle.

Wrap-around:
- fa and pc wrap modulo 2^AW. A fetch of FFFFFE then continues at 000000.
- Queue pointers wrap modulo DEPTH.

Reset mid-operation:
- Drops bus_rd immediately. Any bus_ack afterwards is ignored.

Optional Feature:
Macro: JT900H_FETCH_STALL_EN.
- Defined: adds output stall_cnt[15:0], cleared by reset. It increments by 1 on each cen cycle in which pop!=0 but the pop was ignored for lack of bytes, and saturates at FFFF. pc_load does not clear it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Reset, then idle for 10 cycles -> bus_rd stays 0 and md_valid=0. Then pc_load with pc_in=000100 -> bus_rd=1, bus_addr=000100.
2. Even start with bus_din=3412 then 7856 (ack each) -> md=12, md2=34. After pop=2: md=56, pc=000102. After filling, count reaches DEPTH=4 and no further bus_rd.
3. Odd start, pc_load pc_in=000101, bus_din=AA55 -> only AA enqueued, md=AA. The next bus_addr is 000102.
4. Flush during outstanding read: bus_rd=1 at 000104, pc_load pc_in=002000, ack with 9999 -> queue empty, 99 never appears on md. The next bus_addr is 002000.
5. Simultaneous pop=2 and ack with count=2 -> count=2 with the new bytes at the head. Then pop=2 with count=1 -> ignored, and md is unchanged.
6. Wrap: pc_load FFFFFE, data 2211 -> next bus_addr=000000. With JT900H_FETCH_STALL_EN, three pops on an empty queue give stall_cnt=3.
